// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB peripheral-side responder model.
// Phase encoding, bus widths and the byte-address to word-index mapping.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int NUM_SLV_DEF = 3;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;

  // Byte lane bits and everything above the bank index are dropped
  function automatic logic [ADDR_W-1:0] word_idx(
    input logic [ADDR_W-1:0] addr,
    input int                idx_w
  );
    return (addr >> 2) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// One peripheral register bank: DEPTH x 32 words, synchronous write,
// registered read port, all words cleared by the asynchronous reset.
module apb_reg_bank
  import apb_slave_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_model.sv
// APB responder modelling NUM_SLV peripherals with phase FSM and counters.
// Optional sticky protocol checker enabled by APB_PROTOCOL_CHECK_EN.
module apb_slave_model
  import apb_slave_pkg::*;
#(
  parameter int NUM_SLV = NUM_SLV_DEF,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic [NUM_SLV-1:0] Pselx,
  input  logic               Penable,
  input  logic               Pwrite,
  input  logic [ADDR_W-1:0]  Paddr,
  input  logic [DATA_W-1:0]  Pwdata,
  output logic [DATA_W-1:0]  Prdata,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count,
  output logic [1:0]         apb_state
`ifdef APB_PROTOCOL_CHECK_EN
  ,
  output logic               Perr
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  apb_state_e         state_q, state_d;
  logic [NUM_SLV-1:0] sel_q, rd_sel_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   wr_cnt_q, rd_cnt_q;
  logic               one_hot, multi;
  logic               start, go_access, commit, rd_go;
  logic [DATA_W-1:0]  rdata [NUM_SLV];

  assign one_hot = (Pselx != '0) &&
                   ((Pselx & (Pselx - 1'b1)) == '0);
  assign multi   = (Pselx != '0) && !one_hot;

  assign go_access = (state_q == SETUP) && Penable &&
                     (Pselx == sel_q);
  assign commit    = (state_q == ACCESS);
  assign rd_go     = go_access && !wr_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (one_hot && !Penable) begin
          state_d = SETUP;
          start   = 1'b1;
        end
      end
      SETUP: begin
        state_d = go_access ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (one_hot && !Penable) begin
          state_d = SETUP;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rd_sel_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        sel_q <= Pselx;
        idx_q <= IDX_W'(word_idx(Paddr, IDX_W));
        wr_q  <= Pwrite;
      end
      // Write data is taken from the access-phase bus cycle
      if (start || state_q == SETUP) wdata_q <= Pwdata;
      if (multi)      rd_sel_q <= '0;
      else if (rd_go) rd_sel_q <= sel_q;
      if (commit && wr_q && wr_cnt_q != '1)
        wr_cnt_q <= wr_cnt_q + 1'b1;
      if (commit && !wr_q && rd_cnt_q != '1)
        rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_bank
    apb_reg_bank #(
      .DEPTH(DEPTH)
    ) u_bank (
      .clk_i  (Hclk),
      .rst_i  (Hreset),
      .we_i   (commit && wr_q && sel_q[g]),
      .waddr_i(idx_q),
      .wdata_i(wdata_q),
      .re_i   (rd_go && sel_q[g]),
      .raddr_i(idx_q),
      .rdata_o(rdata[g])
    );
  end

  always_comb begin
    Prdata = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (rd_sel_q[i]) Prdata = Prdata | rdata[i];
  end

  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign apb_state = state_q;

`ifdef APB_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] addr_q;
  logic              perr_q;
  logic              v_multi, v_idle_en, v_abandon, v_change, viol;

  assign v_multi   = multi;
  assign v_idle_en = (state_q == IDLE) && Penable;
  assign v_abandon = (state_q == SETUP) && !go_access;
  assign v_change  = (state_q == SETUP) &&
                     (Paddr != addr_q || Pwrite != wr_q ||
                      Pwdata != wdata_q);
  assign viol      = v_multi | v_idle_en | v_abandon | v_change;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      addr_q <= '0;
      perr_q <= 1'b0;
    end else begin
      if (start) addr_q <= Paddr;
      if (viol)  perr_q <= 1'b1;
    end
  end

  assign Perr = perr_q;

`ifndef SYNTHESIS
  always @(posedge Hclk) begin
    if (!Hreset && viol)
      $display("apb_slave_model: protocol violation%s%s%s%s",
               v_multi   ? " multi-hot-Pselx"   : "",
               v_idle_en ? " Penable-in-idle"   : "",
               v_abandon ? " setup-abandoned"   : "",
               v_change  ? " signal-changed"    : "");
  end
`endif
`endif

endmodule
